pad_scan_controller: RTL and testbench

Scan scheduler for the 8x8 pad matrix. It sequences a 3-bit column index through 0..7 with wrap-around, matching the eight-state column counter used elsewhere in the design. It drives one column at a time, waits a settle interval, samples the 8 row lines and compares them with the stored pad state. Each changed pad is emitted as a press or release event over a valid/ready handshake, and the scan stalls until every change in the current column has been reported.

---
 rtl/pad_scan_controller.sv | 144 ++++++++++++++
 tb/tb_pad_scan_controller.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pad_scan_controller.sv
// Column scan scheduler for an 8x8 pad matrix: drives one column at a time,
// samples the rows after a settle delay and reports each pad change as an event.
module pad_scan_controller #(
   parameter int SETTLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [7:0] row_in,
   output logic [7:0] col_sel,
   output logic [2:0] col_idx,
   output logic       ev_valid,
   input  logic       ev_ready,
   output logic [2:0] ev_col,
   output logic [2:0] ev_row,
   output logic       ev_press,
   output logic       frame_done
);

   typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, REPORT, ADVANCE} state_t;

   localparam logic [7:0] CNT_INIT = 8'(SETTLE_CYCLES - 1);

   function automatic logic [2:0] lowest_set(input logic [7:0] v);
      lowest_set = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (v[i]) lowest_set = 3'(i);
      end
   endfunction

   state_t      state_q, state_d;
   logic [2:0]  col_idx_q, col_idx_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [7:0]  sample_q, sample_d;
   logic [7:0]  diff_q, diff_d;
   logic [63:0] pad_state_q, pad_state_d;
   logic        ev_valid_q, ev_valid_d;
   logic [2:0]  ev_col_q, ev_col_d;
   logic [2:0]  ev_row_q, ev_row_d;
   logic        ev_press_q, ev_press_d;

   logic [2:0]  row_pick;
   logic        slot_free;
   logic [5:0]  col_base;

   always_comb begin
      state_d     = state_q;
      col_idx_d   = col_idx_q;
      cnt_d       = cnt_q;
      sample_d    = sample_q;
      diff_d      = diff_q;
      pad_state_d = pad_state_q;
      ev_valid_d  = ev_valid_q;
      ev_col_d    = ev_col_q;
      ev_row_d    = ev_row_q;
      ev_press_d  = ev_press_q;

      row_pick  = lowest_set(diff_q);
      slot_free = !ev_valid_q || ev_ready;
      col_base  = {col_idx_q, 3'b000};

      // A pending event retires on handshake; a new load below may refill the slot
      if (ev_valid_q && ev_ready) ev_valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (en) begin
               state_d   = SETTLE;
               col_idx_d = 3'd0;
               cnt_d     = CNT_INIT;
            end
         end
         SETTLE: begin
            if (cnt_q == 8'd0) state_d = SAMPLE;
            else               cnt_d   = cnt_q - 8'd1;
         end
         SAMPLE: begin
            sample_d = row_in;
            diff_d   = row_in ^ pad_state_q[col_base +: 8];
            state_d  = REPORT;
         end
         REPORT: begin
            if (diff_q == 8'd0) begin
               state_d = ADVANCE;
            end else if (slot_free) begin
               ev_valid_d                       = 1'b1;
               ev_col_d                         = col_idx_q;
               ev_row_d                         = row_pick;
               ev_press_d                       = sample_q[row_pick];
               pad_state_d[{col_idx_q, row_pick}] = sample_q[row_pick];
               diff_d[row_pick]                 = 1'b0;
            end
         end
         ADVANCE: begin
            cnt_d = CNT_INIT;
            if (col_idx_q == 3'd7) begin
               col_idx_d = 3'd0;
               state_d   = en ? SETTLE : IDLE;
            end else begin
               col_idx_d = col_idx_q + 3'd1;
               state_d   = SETTLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         col_idx_q   <= 3'd0;
         cnt_q       <= 8'd0;
         sample_q    <= 8'd0;
         diff_q      <= 8'd0;
         pad_state_q <= 64'd0;
         ev_valid_q  <= 1'b0;
         ev_col_q    <= 3'd0;
         ev_row_q    <= 3'd0;
         ev_press_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_idx_q   <= col_idx_d;
         cnt_q       <= cnt_d;
         sample_q    <= sample_d;
         diff_q      <= diff_d;
         pad_state_q <= pad_state_d;
         ev_valid_q  <= ev_valid_d;
         ev_col_q    <= ev_col_d;
         ev_row_q    <= ev_row_d;
         ev_press_q  <= ev_press_d;
      end
   end

   // Column drive is dropped in ADVANCE so two columns never overlap
   assign col_sel    = (state_q == SETTLE || state_q == SAMPLE || state_q == REPORT)
                       ? (8'd1 << col_idx_q) : 8'd0;
   assign col_idx    = col_idx_q;
   assign frame_done = (state_q == ADVANCE) && (col_idx_q == 3'd7);
   assign ev_valid   = ev_valid_q;
   assign ev_col     = ev_col_q;
   assign ev_row     = ev_row_q;
   assign ev_press   = ev_press_q;

endmodule

// File: tb/tb_pad_scan_controller.sv
// Directed bench for pad_scan_controller: expected events are queued by the
// stimulus and retired by an independent handshake monitor.
module tb_pad_scan_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [7:0] row_in;
   logic [7:0] col_sel;
   logic [2:0] col_idx;
   logic       ev_valid;
   logic       ev_ready;
   logic [2:0] ev_col;
   logic [2:0] ev_row;
   logic       ev_press;
   logic       frame_done;

   int n_checks = 0;
   int n_fails  = 0;

   logic [7:0] pads [8];
   logic [6:0] exp_q [$];   // {col, row, press}

   pad_scan_controller #(.SETTLE_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .en(en), .row_in(row_in),
      .col_sel(col_sel), .col_idx(col_idx),
      .ev_valid(ev_valid), .ev_ready(ev_ready),
      .ev_col(ev_col), .ev_row(ev_row), .ev_press(ev_press),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Row lines follow the pad matrix of whichever column is driven
   initial begin
      row_in = 8'h00;
      forever begin
         @(negedge clk);
         row_in = 8'h00;
         for (int c = 0; c < 8; c++) if (col_sel[c]) row_in = pads[c];
      end
   end

   // Monitor: sees inputs applied for the coming edge and current outputs
   always @(negedge clk) begin
      #1;
      if (!rst && ev_valid && ev_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_event", {25'd0, ev_col, ev_row, ev_press}, 32'hFFFF_FFFF);
         end else begin
            logic [6:0] e;
            e = exp_q.pop_front();
            chk("event", {25'd0, ev_col, ev_row, ev_press}, {25'd0, e});
         end
      end
   end

   task automatic wait_frames(input int n);
      int seen = 0;
      for (int c = 0; c < 600 && seen < n; c++) begin
         @(negedge clk);
         if (frame_done) seen++;
      end
      chk("frame_wait", seen, n);
   endtask

   task automatic wait_valid(input string name);
      int c = 0;
      while (!ev_valid && c < 300) begin
         @(negedge clk);
         c++;
      end
      chk(name, {31'd0, ev_valid}, 32'd1);
   endtask

   initial begin
      int cnt;
      for (int c = 0; c < 8; c++) pads[c] = 8'h00;
      rst = 1'b1; en = 1'b0; ev_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_col_sel", {24'd0, col_sel}, 32'd0);
      chk("rst_col_idx", {29'd0, col_idx}, 32'd0);
      chk("rst_ev", {26'd0, ev_valid, ev_col, ev_row, ev_press}, 32'd0);
      chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
      rst = 1'b0;

      // Idle with en low
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (col_sel != 8'h00 || col_idx != 3'd0 || ev_valid || frame_done) cnt++;
      end
      chk("idle_quiet", cnt, 0);

      // Two empty frames: each column driven 6 cycles, then one blank cycle
      en = 1'b1;
      for (int i = 0; i < 112; i++) begin
         int k, p;
         logic [7:0] exp_sel;
         @(negedge clk);
         k = (i % 56) / 7;
         p = i % 7;
         exp_sel = (p < 6) ? (8'd1 << k) : 8'd0;
         if (col_sel !== exp_sel) chk($sformatf("walk_col_sel_%0d", i), {24'd0, col_sel}, {24'd0, exp_sel});
         if (frame_done !== (i % 56 == 55)) chk($sformatf("walk_frame_done_%0d", i), {31'd0, frame_done}, {31'd0, (i % 56 == 55)});
         if (i == 30) chk("walk_mid_col_sel", {24'd0, col_sel}, 32'h10);
         if (i == 55 || i == 111) chk("frame_pulse", {31'd0, frame_done}, 32'd1);
      end

      // Single press, steady, then release
      pads[2] = 8'h10;
      exp_q.push_back({3'd2, 3'd4, 1'b1});
      wait_frames(2);
      chk("press_drained", exp_q.size(), 0);
      wait_frames(1);
      pads[2] = 8'h00;
      exp_q.push_back({3'd2, 3'd4, 1'b0});
      wait_frames(2);
      chk("release_drained", exp_q.size(), 0);

      // Backpressure with two rows changing in column 5
      ev_ready = 1'b0;
      pads[5] = 8'h81;
      exp_q.push_back({3'd5, 3'd0, 1'b1});
      exp_q.push_back({3'd5, 3'd7, 1'b1});
      wait_valid("bp_valid");
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!ev_valid || ev_col != 3'd5 || ev_row != 3'd0 || !ev_press || col_sel != 8'h20) cnt++;
      end
      chk("bp_hold", cnt, 0);
      ev_ready = 1'b1;
      cnt = 0;
      while (col_sel != 8'h40 && cnt < 50) begin
         @(negedge clk);
         cnt++;
      end
      chk("bp_next_col", {24'd0, col_sel}, 32'h40);
      chk("bp_drained", exp_q.size(), 0);

      // en dropped mid-frame: frame completes, then IDLE
      cnt = 0;
      while (col_idx != 3'd3 && cnt < 200) begin
         @(negedge clk);
         cnt++;
      end
      chk("reach_col3", {29'd0, col_idx}, 32'd3);
      en = 1'b0;
      cnt = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (frame_done) cnt++;
      end
      chk("endrop_frames", cnt, 1);
      chk("endrop_col_sel", {24'd0, col_sel}, 32'd0);
      chk("endrop_col_idx", {29'd0, col_idx}, 32'd0);

      // Reset while an event is held; pad state must be rebuilt afterwards
      pads[1] = 8'h01;
      ev_ready = 1'b0;
      en = 1'b1;
      wait_valid("rr_valid");
      chk("rr_event", {26'd0, ev_col, ev_row}, {26'd0, 3'd1, 3'd0});
      rst = 1'b1; en = 1'b0;
      @(negedge clk);
      chk("rr_col_sel", {24'd0, col_sel}, 32'd0);
      chk("rr_col_idx", {29'd0, col_idx}, 32'd0);
      chk("rr_ev", {26'd0, ev_valid, ev_col, ev_row, ev_press}, 32'd0);
      chk("rr_frame_done", {31'd0, frame_done}, 32'd0);
      rst = 1'b0;
      ev_ready = 1'b1;
      exp_q.push_back({3'd1, 3'd0, 1'b1});
      exp_q.push_back({3'd5, 3'd0, 1'b1});
      exp_q.push_back({3'd5, 3'd7, 1'b1});
      en = 1'b1;
      wait_frames(2);
      chk("rr_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
